// File: rtl/prog_counter_n.sv
// prog_counter_n: parametrised programmable up/down counter with a
// programmable terminal value, wrap/saturate modes and a one-cycle
// terminal-count pulse.
// Optional feature macro: PROG_COUNTER_PRESCALE_EN (adds a clock-enable
// prescaler so the counter steps once per presc_div+1 enabled cycles).
// rst_n is asynchronous and active-high: the block is held in reset while
// rst_n is 1.

module prog_counter_n #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] presc_div,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  at_bound
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic [WIDTH-1:0] count_next_s;
  logic             tc_next_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] dec_s;
  logic             tick_s;
  logic             step_s;

`ifdef PROG_COUNTER_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1'b1);

  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] presc_next_s;

  // Tick when the prescaler reaches the programmed divisor.
  always_comb begin
    tick_s = (presc_r == presc_div);
  end

  // Prescaler advances on enabled, non-load edges; load clears it, en low freezes it.
  always_comb begin
    presc_next_s = presc_r;
    if (load) begin
      presc_next_s = PRESC_ZERO;
    end else if (en) begin
      if (tick_s) begin
        presc_next_s = PRESC_ZERO;
      end else begin
        presc_next_s = presc_r + PRESC_ONE;
      end
    end else begin
      presc_next_s = presc_r;
    end
  end

  // Prescaler register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      presc_r <= PRESC_ZERO;
    end else begin
      presc_r <= presc_next_s;
    end
  end
`else
  // presc_div is kept on the port list for compatibility but has no effect here.
  logic presc_unused_s;
  assign presc_unused_s = ^presc_div;

  // Without the prescaler every enabled edge is a step edge.
  always_comb begin
    tick_s = 1'b1;
  end
`endif

  // Shared arithmetic: increment/decrement wrap modulo 2^WIDTH, load value clamped into range.
  always_comb begin
    inc_s  = count_r + CNT_ONE;
    dec_s  = count_r - CNT_ONE;
    step_s = en & ~load & tick_s;
    if (load_val > limit) begin
      load_clamp_s = limit;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Next count and terminal-count pulse; load beats step, step beats hold.
  always_comb begin
    count_next_s = count_r;
    tc_next_s    = 1'b0;
    if (load) begin
      count_next_s = load_clamp_s;
      tc_next_s    = 1'b0;
    end else if (step_s) begin
      if (dir) begin
        if (count_r < limit) begin
          count_next_s = inc_s;
          tc_next_s    = sat & (inc_s == limit);
        end else if (sat) begin
          // A count above limit (limit lowered at run time) snaps onto limit and pulses.
          count_next_s = limit;
          tc_next_s    = (count_r != limit);
        end else begin
          count_next_s = CNT_ZERO;
          tc_next_s    = 1'b1;
        end
      end else begin
        if (count_r != CNT_ZERO) begin
          count_next_s = dec_s;
          tc_next_s    = sat & (count_r == CNT_ONE);
        end else if (sat) begin
          count_next_s = CNT_ZERO;
          tc_next_s    = 1'b0;
        end else begin
          count_next_s = limit;
          tc_next_s    = 1'b1;
        end
      end
    end else begin
      count_next_s = count_r;
      tc_next_s    = 1'b0;
    end
  end

  // Count and tc registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_r <= CNT_ZERO;
      tc_r    <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tc_r    <= tc_next_s;
    end
  end

  // Boundary flag follows count, limit and dir with no register stage.
  always_comb begin
    if (dir) begin
      at_bound = (count_r >= limit);
    end else begin
      at_bound = (count_r == CNT_ZERO);
    end
  end

  assign count = count_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_prog_counter_n.sv
// Self-checking bench for prog_counter_n: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.

module tb_prog_counter_n;

  localparam int WIDTH = 8;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] limit;
  logic [PW-1:0]    presc_div;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_bound;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_count;
  int m_tc;
  int m_presc;

  prog_counter_n #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .limit(limit), .presc_div(presc_div),
    .count(count), .tc(tc), .at_bound(at_bound)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_tc    = 0;
    m_presc = 0;
  endtask

  // Apply the counter rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int  lim;
    int  cur;
    int  nxt;
    bit  tick;
    bit  bound;
    lim = int'(limit);
    cur = m_count;
    if (rst_n) begin
      model_reset();
    end else if (load) begin
      m_count = (int'(load_val) > lim) ? lim : int'(load_val);
      m_tc    = 0;
      m_presc = 0;
    end else if (!en) begin
      m_tc = 0;
    end else begin
`ifdef PROG_COUNTER_PRESCALE_EN
      tick    = (m_presc == int'(presc_div));
      m_presc = tick ? 0 : (m_presc + 1) % (1 << PW);
`else
      tick = 1'b1;
`endif
      if (!tick) begin
        m_tc = 0;
      end else if (dir) begin
        bound   = (cur >= lim);
        nxt     = bound ? (sat ? lim : 0) : cur + 1;
        m_tc    = sat ? int'(nxt == lim && cur != lim) : int'(bound);
        m_count = nxt;
      end else begin
        bound   = (cur == 0);
        nxt     = bound ? (sat ? 0 : lim) : cur - 1;
        m_tc    = sat ? int'(nxt == 0 && cur != 0) : int'(bound);
        m_count = nxt;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_bound;
    exp_bound = dir ? int'(m_count >= int'(limit)) : int'(m_count == 0);
    check({tag, ".count"}, 32'(count), m_count);
    check({tag, ".tc"}, 32'(tc), m_tc);
    check({tag, ".at_bound"}, 32'(at_bound), exp_bound);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int sd_cnt[5];
    int sd_tc[5];
    sd_cnt = '{2, 1, 0, 0, 0};
    sd_tc  = '{0, 0, 1, 0, 0};

    rst_n = 1'b1; en = 1'b0; load = 1'b0; load_val = 8'd0; dir = 1'b0;
    sat = 1'b0; limit = 8'd0; presc_div = 4'd0;
    model_reset();

    // Reset state
    repeat (2) cycle("reset");
    #3 rst_n = 1'b0;

    // Wrap up from 0 with limit 5
    limit = 8'd5; sat = 1'b0; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle("wrap_up");
      check("wrap_up.seq", 32'(count), (i + 1) % 6);
      check("wrap_up.tcseq", 32'(tc), 32'(((i + 1) % 6) == 0));
    end

    // Reset asserted mid-count between edges
    limit = 8'd100; load = 1'b1; load_val = 8'd37;
    cycle("rst_mid.load");
    check("rst_mid.37", 32'(count), 32'd37);
    load = 1'b0;
    #3 rst_n = 1'b1;
    #1;
    model_reset();
    check("rst_mid.count0", 32'(count), 32'd0);
    check("rst_mid.tc0", 32'(tc), 32'd0);
    #1 rst_n = 1'b0;
    cycle("rst_mid.resume");
    check("rst_mid.resume1", 32'(count), 32'd1);

    // Saturate down from 3
    load = 1'b1; load_val = 8'd3; limit = 8'd10; sat = 1'b1; dir = 1'b0;
    cycle("sat_down.load");
    check("sat_down.3", 32'(count), 32'd3);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("sat_down");
      check("sat_down.seq", 32'(count), sd_cnt[i]);
      check("sat_down.tcseq", 32'(tc), sd_tc[i]);
    end

    // Load clamp and load-over-step priority
    limit = 8'd20; load = 1'b1; load_val = 8'd200; sat = 1'b0; dir = 1'b1;
    cycle("clamp");
    check("clamp.20", 32'(count), 32'd20);
    check("clamp.tc", 32'(tc), 32'd0);
    load = 1'b0;
    cycle("clamp.wrap");
    check("clamp.wrap0", 32'(count), 32'd0);
    check("clamp.wraptc", 32'(tc), 32'd1);

    // Run-time limit drop below the count, wrap then saturate
    limit = 8'd200; load = 1'b1; load_val = 8'd50;
    cycle("drop.load");
    limit = 8'd10; load = 1'b0;
    cycle("drop.wrap");
    check("drop.wrap0", 32'(count), 32'd0);
    limit = 8'd200; load = 1'b1; sat = 1'b1;
    cycle("drop.load2");
    limit = 8'd10; load = 1'b0;
    cycle("drop.sat");
    check("drop.sat10", 32'(count), 32'd10);
    check("drop.sattc", 32'(tc), 32'd1);
    cycle("drop.held");
    check("drop.heldtc", 32'(tc), 32'd0);

    // Prescaler phase with an en-low gap
    presc_div = 4'd2; limit = 8'd255; sat = 1'b0; dir = 1'b1;
    load = 1'b1; load_val = 8'd0;
    cycle("presc.load");
    load = 1'b0;
    repeat (5) cycle("presc.run");
    en = 1'b0;
    repeat (4) cycle("presc.hold");
    en = 1'b1;
    repeat (8) cycle("presc.resume");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) sat = ~sat;
      if ($urandom_range(0, 29) == 0) begin
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 49) == 0) presc_div = 4'($urandom_range(0, 3));
      cycle("rand");
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b1;
        #1;
        model_reset();
        check("rand.async_count", 32'(count), 32'd0);
        check("rand.async_tc", 32'(tc), 32'd0);
        #1 rst_n = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
